// File: rtl/freqdiv_prog_if.sv
// Configuration/handshake and divided-output bundle for freqdiv_prog.
// The master drives run enable and load requests; the slave returns the divided outputs.
interface freqdiv_prog_if #(
    parameter int WIDTH = 27
);
    logic             en;
    logic [WIDTH-1:0] period_in;
    logic [WIDTH-1:0] high_in;
    logic             load_valid;
    logic             load_ready;
    logic             f_out;
    logic             tick;
    logic [WIDTH-1:0] cnt;

    modport master (
        output en, period_in, high_in, load_valid,
        input  load_ready, f_out, tick, cnt
    );

    modport slave (
        input  en, period_in, high_in, load_valid,
        output load_ready, f_out, tick, cnt
    );
endinterface

// File: rtl/freqdiv_prog.sv
// Programmable divider: square wave of runtime period/high time plus end-of-period tick.
// FREQDIV_DUTY_EN enables a programmable high time; otherwise the high time is period>>1.
module freqdiv_prog #(
    parameter int          WIDTH          = 27,
    parameter int unsigned DEFAULT_PERIOD = 100_000_000,
    parameter int unsigned DEFAULT_HIGH   = 50_000_000
) (
    input  logic            f_crystal,
    input  logic            rst,
    freqdiv_prog_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_STOPPED,
        ST_RUNNING,
        ST_RUN_PEND
    } state_t;

    localparam logic [WIDTH-1:0] P_DEF = WIDTH'(DEFAULT_PERIOD);
`ifdef FREQDIV_DUTY_EN
    localparam logic [WIDTH-1:0] H_DEF = WIDTH'(DEFAULT_HIGH);
`else
    localparam logic [WIDTH-1:0] H_DEF = P_DEF >> 1;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high;
    logic [WIDTH-1:0] r_sh_period;
    logic [WIDTH-1:0] r_sh_high;
    logic             r_pending;
    logic [WIDTH-1:0] r_cnt;
    logic             r_f_out;
    logic             r_tick;

    logic             w_xfer;
    logic [WIDTH-1:0] w_in_period;
    logic [WIDTH-1:0] w_in_high;
    logic             w_boundary;
    logic             w_apply_run;
    logic [WIDTH-1:0] w_nx_period;
    logic [WIDTH-1:0] w_nx_high;
    logic [WIDTH-1:0] w_nx_cnt;
    logic [WIDTH-1:0] w_stop_high;

    assign w_xfer      = bus.load_valid && !r_pending;
    assign w_in_period = (bus.period_in < WIDTH'(2)) ? WIDTH'(2) : bus.period_in;
`ifdef FREQDIV_DUTY_EN
    assign w_in_high   = bus.high_in;
`else
    logic w_unused_high;
    assign w_unused_high = ^{bus.high_in, WIDTH'(DEFAULT_HIGH)};
    assign w_in_high     = w_in_period >> 1;
`endif

    // A load accepted in the boundary cycle bypasses the shadow and takes effect at once.
    assign w_boundary  = (r_cnt == r_period - WIDTH'(1));
    assign w_apply_run = w_boundary && (r_pending || w_xfer);
    assign w_nx_period = !w_apply_run ? r_period : (r_pending ? r_sh_period : w_in_period);
    assign w_nx_high   = !w_apply_run ? r_high   : (r_pending ? r_sh_high   : w_in_high);
    assign w_nx_cnt    = w_boundary ? '0 : r_cnt + WIDTH'(1);
    assign w_stop_high = r_pending ? r_sh_high : r_high;

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge f_crystal or posedge rst) begin
        if (rst) begin
            r_state     <= ST_STOPPED;
            r_period    <= P_DEF;
            r_high      <= H_DEF;
            r_sh_period <= P_DEF;
            r_sh_high   <= H_DEF;
            r_pending   <= 1'b0;
            r_cnt       <= '0;
            r_f_out     <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_sh_period <= w_in_period;
                r_sh_high   <= w_in_high;
            end
            case (r_state)
                ST_RUNNING, ST_RUN_PEND: begin
                    if (!bus.en) begin
                        r_state   <= ST_STOPPED;
                        r_cnt     <= '0;
                        r_f_out   <= 1'b0;
                        r_tick    <= 1'b0;
                        r_pending <= r_pending || w_xfer;
                    end else begin
                        r_cnt   <= w_nx_cnt;
                        r_f_out <= (w_nx_cnt < w_nx_high);
                        r_tick  <= (w_nx_cnt == w_nx_period - WIDTH'(1));
                        if (w_apply_run) begin
                            r_period  <= w_nx_period;
                            r_high    <= w_nx_high;
                            r_pending <= 1'b0;
                            r_state   <= ST_RUNNING;
                        end else if (w_xfer) begin
                            r_pending <= 1'b1;
                            r_state   <= ST_RUN_PEND;
                        end
                    end
                end
                default: begin
                    r_cnt  <= '0;
                    r_tick <= 1'b0;
                    if (r_pending) begin
                        r_period  <= r_sh_period;
                        r_high    <= r_sh_high;
                        r_pending <= 1'b0;
                    end else begin
                        r_pending <= w_xfer;
                    end
                    // A load captured while stopped stays pending into the run state.
                    if (bus.en) begin
                        r_f_out <= (w_stop_high != '0);
                        r_state <= (!r_pending && w_xfer) ? ST_RUN_PEND : ST_RUNNING;
                    end else begin
                        r_f_out <= 1'b0;
                        r_state <= ST_STOPPED;
                    end
                end
            endcase
        end
    end

    assign bus.load_ready = !r_pending;
    assign bus.f_out      = r_f_out;
    assign bus.tick       = r_tick;
    assign bus.cnt        = r_cnt;
endmodule

// File: tb/tb_freqdiv_prog.sv
// Self-checking bench for freqdiv_prog: vector table, corner sequences, random run vs model.
// Works with or without FREQDIV_DUTY_EN defined.
module tb_freqdiv_prog;
`ifdef FREQDIV_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif
    localparam int H_DEF  = DUTY ? 3 : 5;
    localparam int H_ZERO = DUTY ? 0 : 1;

    logic f_crystal = 1'b0;
    logic rst;
    freqdiv_prog_if #(.WIDTH(8)) bus ();

    freqdiv_prog #(
        .WIDTH(8),
        .DEFAULT_PERIOD(10),
        .DEFAULT_HIGH(3)
    ) dut (
        .f_crystal(f_crystal),
        .rst(rst),
        .bus(bus)
    );

    always #5 f_crystal = ~f_crystal;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: position within the current period and the active/shadow settings.
    bit m_run, m_pend;
    int m_per, m_high, m_pos, m_sh_per, m_sh_high;

    function automatic void model_reset();
        m_run = 0; m_pend = 0; m_per = 10; m_high = H_DEF; m_pos = 0;
    endfunction

    function automatic void model_step(input bit e, input bit lv, input int p, input int h);
        bit xfer;
        bit last;
        int np, nh;
        xfer = lv && !m_pend;
        np   = (p < 2) ? 2 : p;
        nh   = DUTY ? h : np / 2;
        if (!m_run) begin
            if (m_pend) begin
                m_per = m_sh_per; m_high = m_sh_high; m_pend = 0;
            end else if (xfer) begin
                m_sh_per = np; m_sh_high = nh; m_pend = 1;
            end
            if (e) begin m_run = 1; m_pos = 0; end
        end else if (!e) begin
            m_run = 0; m_pos = 0;
            if (xfer) begin m_sh_per = np; m_sh_high = nh; m_pend = 1; end
        end else begin
            last  = (m_pos == m_per - 1);
            m_pos = (m_pos + 1) % m_per;
            if (last && m_pend) begin
                m_per = m_sh_per; m_high = m_sh_high; m_pend = 0;
            end else if (last && xfer) begin
                m_per = np; m_high = nh;
            end else if (xfer) begin
                m_sh_per = np; m_sh_high = nh; m_pend = 1;
            end
        end
    endfunction

    task automatic drive_cycle(input bit e, input bit lv, input int p, input int h);
        bus.en = e; bus.load_valid = lv; bus.period_in = 8'(p); bus.high_in = 8'(h);
        @(posedge f_crystal);
        model_step(e, lv, p, h);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " cnt"},   int'(bus.cnt),        m_run ? m_pos : 0);
        check({tag, " f_out"}, int'(bus.f_out),      int'(m_run && m_pos < m_high));
        check({tag, " tick"},  int'(bus.tick),       int'(m_run && m_pos == m_per - 1));
        check({tag, " ready"}, int'(bus.load_ready), int'(!m_pend));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " cnt"},   int'(bus.cnt), 0);
        check({tag, " f_out"}, int'(bus.f_out), 0);
        check({tag, " tick"},  int'(bus.tick), 0);
        check({tag, " ready"}, int'(bus.load_ready), 1);
    endtask

    task automatic do_reset(input string tag);
        bus.en = 0; bus.load_valid = 0; bus.period_in = 0; bus.high_in = 0;
        rst = 1'b1;
        #2;
        check_reset_vals(tag);
        model_reset();
        rst = 1'b0;
    endtask

    typedef struct {
        bit en;
        bit lv;
        int p;
        int h;
        int exp_cnt;
        bit exp_f;
        bit exp_tick;
        bit exp_ready;
    } vec_t;

    vec_t vecs[24];

    initial begin
        int c, per, hi, hcount;

        for (int i = 0; i < 24; i++) begin
            vecs[i].en = 1;
            vecs[i].lv = (i == 6) || (i == 18);
            vecs[i].p  = (i == 6) ? 4 : 0;
            vecs[i].h  = (i == 6) ? 2 : 0;
            if (i < 10)      begin c = i;            per = 10; hi = H_DEF;  end
            else if (i < 18) begin c = (i - 10) % 4; per = 4;  hi = 2;      end
            else             begin c = (i - 18) % 2; per = 2;  hi = H_ZERO; end
            vecs[i].exp_cnt   = c;
            vecs[i].exp_f     = (c < hi);
            vecs[i].exp_tick  = (c == per - 1);
            vecs[i].exp_ready = !(i >= 6 && i <= 9);
        end

        rst = 1'b1;
        bus.en = 0; bus.load_valid = 0; bus.period_in = 0; bus.high_in = 0;
        repeat (2) @(posedge f_crystal);
        #1;
        do_reset("reset");

        // Default waveform, load at cnt=5, load at the boundary cycle with period 0.
        for (int i = 0; i < 24; i++) begin
            drive_cycle(vecs[i].en, vecs[i].lv, vecs[i].p, vecs[i].h);
            check($sformatf("vec%0d cnt", i),   int'(bus.cnt),        vecs[i].exp_cnt);
            check($sformatf("vec%0d f_out", i), int'(bus.f_out),      int'(vecs[i].exp_f));
            check($sformatf("vec%0d tick", i),  int'(bus.tick),       int'(vecs[i].exp_tick));
            check($sformatf("vec%0d ready", i), int'(bus.load_ready), int'(vecs[i].exp_ready));
        end

        // en dropped at cnt=6, then restarted.
        do_reset("reset_a");
        repeat (7) drive_cycle(1, 0, 0, 0);
        check("stop cnt_before", int'(bus.cnt), 6);
        drive_cycle(0, 0, 0, 0);
        check("stop cnt", int'(bus.cnt), 0);
        check("stop f_out", int'(bus.f_out), 0);
        check("stop tick", int'(bus.tick), 0);
        drive_cycle(0, 0, 0, 0);
        check_model("stopped");
        drive_cycle(1, 0, 0, 0);
        check("restart cnt", int'(bus.cnt), 0);
        check("restart f_out", int'(bus.f_out), 1);

        // Async reset mid-period discards a pending load.
        do_reset("reset_b");
        repeat (4) drive_cycle(1, 0, 0, 0);
        drive_cycle(1, 1, 5, 1);
        check("pend ready", int'(bus.load_ready), 0);
        drive_cycle(1, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1, 0, 0, 0);
            check_model($sformatf("post_rst%0d", i));
        end
        check("post_rst cnt9", int'(bus.cnt), 9);
        check("post_rst tick9", int'(bus.tick), 1);

        // Period 7 / high 6: high time depends on the duty build option.
        do_reset("reset_c");
        drive_cycle(1, 0, 0, 0);
        drive_cycle(1, 1, 7, 6);
        repeat (8) drive_cycle(1, 0, 0, 0);
        hcount = 0;
        for (int i = 0; i < 7; i++) begin
            drive_cycle(1, 0, 0, 0);
            check_model($sformatf("p7_%0d", i));
            if (bus.f_out) hcount++;
        end
        check("p7 high_cycles", hcount, DUTY ? 6 : 3);
        check("p7 end_tick", int'(bus.tick), 1);

        // Randomised run against the model.
        do_reset("reset_r");
        for (int i = 0; i < 3000; i++) begin
            drive_cycle($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0,
                        int'($urandom_range(0, 15)), int'($urandom_range(0, 18)));
            check_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
